regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Round-robin arbiter sharing the register file's single write port between NREQ write-back sources.
//  Sources are the ALU pipe, the load unit and the mul/div unit.
//  Each source presents a valid/ready request; one grant per cycle.
//  Granted write is registered and driven onto reg_we/reg_wa/reg_wd one cycle later.
//  Sits between the execution units and regfile.
//  Saturating contention counter for performance debug.
// PARAMETERS
//  NREQ    3   number of write-back requesters, legal range 2..8
//  CNT_W   16  width of the contention counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous, active-low reset
//  req_valid  in   NREQ       request i pending
//  req_ready  out  NREQ       request i accepted this cycle (one-hot or zero)
//  req_wa     in   5*NREQ     dest reg of req i at [5*i +: 5]
//  req_wd     in   32*NREQ    write data of req i at [32*i +: 32]
//  arb_hold   in   1          1 = freeze: no grants
//  cnt_clr    in   1          synchronous clear of conf_cnt
//  reg_we     out  1          to regfile write enable (registered)
//  reg_wa     out  5          to regfile write address (registered)
//  reg_wd     out  32         to regfile write data (registered)
//  wb_src     out  3          index of requester driving current reg_we (registered)
//  conf_cnt   out  CNT_W      cycles with >=2 valid requests while not held
// BEHAVIOUR
//  Reset (rst=0, async): reg_we=0, reg_wa=0, reg_wd=0, wb_src=0, ptr=0, conf_cnt=0.
//  While rst=0, req_ready=0.
//  Arbitration (combinational, per cycle):
//   - search req_valid from index ptr upward, modulo NREQ; first set bit i wins.
//   - req_ready[i]=1 for the winner only; all 0 if arb_hold=1 or no valid request.
//  Handshake: transfer when req_valid[i]&&req_ready[i].
//   - source holds valid/wa/wd stable until transfer; valid must not drop before it.
//  On transfer of i at edge N, over cycle N+1:
//   - reg_we=(req_wa_i!=0), reg_wa=req_wa_i, reg_wd=req_wd_i, wb_src=i.
//   - ptr<=(i+1)%NREQ.
//  No transfer: reg_we<=0 next cycle; reg_wa/reg_wd/wb_src hold previous values; ptr unchanged.
//  Writes to r0: accepted (ready asserted, ptr advances) but reg_we stays 0; r0 never written.
//  Latency: 1 cycle request-accept to reg_we; regfile commits on the following edge.
//  Throughput: 1 write/cycle; each source waits at most NREQ-1 grants.
//  arb_hold=1: no grants, ptr frozen, conf_cnt not incremented.
//   - a transfer accepted the edge before hold rises still completes.
//  conf_cnt: +1 per cycle with popcount(req_valid)>=2 and arb_hold=0.
//   - saturates at 2^CNT_W-1.
//   - cnt_clr=1 forces 0 and wins over a simultaneous increment.
//  Reset mid-operation: the registered pending write is discarded (reg_we=0 immediately);
//   unacknowledged requests are re-arbitrated from ptr=0 after release.
// CONFIGURATION
//  Macro WB_ARB_FWD_EN defined:
//   - adds ports fwd_ra1 in 5, fwd_ra2 in 5, fwd_hit1 out 1, fwd_hit2 out 1, fwd_wd out 32.
//   - fwd_hitK = reg_we && reg_wa==fwd_raK && reg_wa!=0 (combinational).
//   - fwd_wd = reg_wd.
//   - covers the read-during-write cycle so readers see the in-flight value.
//  Macro undefined: fwd ports absent, no forwarding logic; readers see the old regfile value in the reg_we cycle.
// TESTING
//  Reset value check: rst=0 with all req_valid=1 -> req_ready=0, reg_we=0, conf_cnt=0.
//  Single source: req_valid=3'b010, wa=5, wd=0xDEADBEEF -> ready[1] same cycle;
//   next cycle reg_we=1, reg_wa=5, reg_wd=0xDEADBEEF, wb_src=1.
//  Round robin: all three valid continuously -> grant order 0,1,2,0,1,2; conf_cnt increments every cycle.
//  r0 drop: req0 wa=0 wd=0x1234 -> ready[0]=1, next-cycle reg_we=0; ptr advances to 1.
//  Hold: arb_hold=1 for 4 cycles with req_valid=3'b111 -> ready=0, reg_we=0, conf_cnt unchanged.
//   - release -> grant resumes at frozen ptr.
//  Counter edges: preload to 0xFFFF with contention -> stays 0xFFFF.
//   - cnt_clr=1 same cycle as contention -> 0.
//  Mid-op reset: assert rst=0 in cycle after transfer -> reg_we=0 immediately, no regfile write.
//  With WB_ARB_FWD_EN: write r7=0xA5A5A5A5, fwd_ra1=7, fwd_ra2=0 -> fwd_hit1=1, fwd_hit2=0, fwd_wd=0xA5A5A5A5.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter
// ----------------------------------------------------------------------------
// Shares the register file's single write port between NREQ write-back
// sources (ALU pipe, load unit, mul/div unit). Each cycle at most one
// requester is accepted, chosen round-robin from a rotating pointer. The
// accepted write is registered and appears on reg_we/reg_wa/reg_wd one cycle
// later, so the register file commits it on the following edge. Writes that
// target r0 are accepted (the source is released and the pointer advances)
// but never raise reg_we.
//
// A saturating counter (conf_cnt) counts cycles in which two or more sources
// compete while the arbiter is not held. It is used for performance debug.
//
// Optional feature (macro WB_ARB_FWD_EN):
//   Adds a combinational forwarding path so register readers in the same
//   cycle as reg_we see the in-flight value instead of the stale regfile
//   entry. Without the macro the ports and the logic are absent.
//
// Parameters:
//   NREQ   number of write-back requesters (2..8)
//   CNT_W  width of the contention counter
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_valid  [NREQ]     request i pending
//   req_ready  [NREQ]     request i accepted this cycle (one-hot or zero)
//   req_wa     [5*NREQ]   destination register of request i at [5*i +: 5]
//   req_wd     [32*NREQ]  write data of request i at [32*i +: 32]
//   arb_hold   1 = no grants, pointer and counter frozen
//   cnt_clr    synchronous clear of conf_cnt (wins over increment)
//   reg_we     registered regfile write enable
//   reg_wa     registered regfile write address
//   reg_wd     registered regfile write data
//   wb_src     registered index of the requester behind the current write
//   conf_cnt   saturating count of contended, non-held cycles
//   fwd_ra1/2  (WB_ARB_FWD_EN) read addresses of the two regfile read ports
//   fwd_hit1/2 (WB_ARB_FWD_EN) read address matches the in-flight write
//   fwd_wd     (WB_ARB_FWD_EN) in-flight write data
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [5*NREQ-1:0]  req_wa,
    input  logic [32*NREQ-1:0] req_wd,
    input  logic               arb_hold,
    input  logic               cnt_clr,
    output logic               reg_we,
    output logic [4:0]         reg_wa,
    output logic [31:0]        reg_wd,
    output logic [2:0]         wb_src,
`ifdef WB_ARB_FWD_EN
    input  logic [4:0]         fwd_ra1,
    input  logic [4:0]         fwd_ra2,
    output logic               fwd_hit1,
    output logic               fwd_hit2,
    output logic [31:0]        fwd_wd,
`endif
    output logic [CNT_W-1:0]   conf_cnt
);

    localparam int PTR_W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("regfile_wb_arbiter: NREQ must be in 2..8");
    end

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    next_ptr;
    logic [2*NREQ-1:0]   req_dbl;
    logic [NREQ-1:0]     req_rot;
    logic [PTR_W-1:0]    win_off;
    logic [PTR_W:0]      win_sum;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_vld;
    logic [4:0]          sel_wa;
    logic [31:0]         sel_wd;
    logic                contention;

    // ------------------------------------------------------------------------
    // Round-robin search. The request vector is rotated so that bit 0 of
    // req_rot is the requester at ptr; the lowest set bit of req_rot is the
    // winner, and its offset is added back to ptr modulo NREQ.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        req_dbl   = {req_valid, req_valid} >> ptr;
        req_rot   = req_dbl[NREQ-1:0];
        win_off   = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_vld && req_rot[k]) begin
                grant_vld = 1'b1;
                win_off   = PTR_W'(k);
            end
        end

        win_sum = {1'b0, ptr} + {1'b0, win_off};
        if (win_sum >= (PTR_W+1)'(NREQ)) begin
            win_sum = win_sum - (PTR_W+1)'(NREQ);
        end
        grant_idx = win_sum[PTR_W-1:0];

        // No grant while held or while reset is asserted.
        if (arb_hold || !rst) begin
            grant_vld = 1'b0;
        end
    end

    // One-hot ready, payload mux and pointer successor of the winner.
    always_comb begin
        req_ready = '0;
        sel_wa    = '0;
        sel_wd    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                req_ready[i] = grant_vld;
                sel_wa       = req_wa[5*i +: 5];
                sel_wd       = req_wd[32*i +: 32];
            end
        end

        if (grant_idx == PTR_W'(NREQ-1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + PTR_W'(1);
        end
    end

    // Two or more requests pending: clearing the lowest set bit leaves
    // something behind.
    assign contention = |(req_valid & (req_valid - NREQ'(1)));

    // ------------------------------------------------------------------------
    // Registered write port. reg_wa/reg_wd/wb_src keep their last value when
    // nothing transfers; only reg_we drops. A reset discards a pending write.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        if (!rst) begin
            ptr    <= '0;
            reg_we <= 1'b0;
            reg_wa <= '0;
            reg_wd <= '0;
            wb_src <= '0;
        end else begin
            reg_we <= grant_vld && (sel_wa != 5'd0);
            if (grant_vld) begin
                reg_wa <= sel_wa;
                reg_wd <= sel_wd;
                wb_src <= 3'(grant_idx);
                ptr    <= next_ptr;
            end
        end
    end

    // Contention counter: clear wins, otherwise saturating increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_cnt <= '0;
        end else if (cnt_clr) begin
            conf_cnt <= '0;
        end else if (contention && !arb_hold && (conf_cnt != '1)) begin
            conf_cnt <= conf_cnt + CNT_W'(1);
        end
    end

`ifdef WB_ARB_FWD_EN
    // Bypass for readers in the cycle the write is presented to the regfile.
    // r0 never matches since it is never written.
    assign fwd_hit1 = reg_we && (reg_wa == fwd_ra1) && (reg_wa != 5'd0);
    assign fwd_hit2 = reg_we && (reg_wa == fwd_ra2) && (reg_wa != 5'd0);
    assign fwd_wd   = reg_wd;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for regfile_wb_arbiter. Two instances share stimulus:
// the default one (CNT_W=16) and a narrow-counter one (CNT_W=4) so counter
// saturation is reached in a few cycles. A reference model evaluates each
// cycle at the falling edge, checks req_ready, and queues the expected
// registered outputs; a monitor pops the queue after the next rising edge.
// Directed sections follow the documented scenarios, then a randomized run.
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int CW   = 16;
    localparam int CWS  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready, req_ready_s;
    logic [5*NREQ-1:0] req_wa;
    logic [32*NREQ-1:0] req_wd;
    logic              arb_hold, cnt_clr;
    logic              reg_we, reg_we_s;
    logic [4:0]        reg_wa, reg_wa_s;
    logic [31:0]       reg_wd, reg_wd_s;
    logic [2:0]        wb_src, wb_src_s;
    logic [CW-1:0]     conf_cnt;
    logic [CWS-1:0]    conf_cnt_s;
`ifdef WB_ARB_FWD_EN
    logic [4:0]        fwd_ra1, fwd_ra2;
    logic              fwd_hit1, fwd_hit2, fwd_hit1_s, fwd_hit2_s;
    logic [31:0]       fwd_wd, fwd_wd_s;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ), .CNT_W(CW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .arb_hold  (arb_hold),
        .cnt_clr   (cnt_clr),
        .reg_we    (reg_we),
        .reg_wa    (reg_wa),
        .reg_wd    (reg_wd),
        .wb_src    (wb_src),
`ifdef WB_ARB_FWD_EN
        .fwd_ra1   (fwd_ra1),
        .fwd_ra2   (fwd_ra2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_wd    (fwd_wd),
`endif
        .conf_cnt  (conf_cnt)
    );

    regfile_wb_arbiter #(.NREQ(NREQ), .CNT_W(CWS)) u_dut_s (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready_s),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .arb_hold  (arb_hold),
        .cnt_clr   (cnt_clr),
        .reg_we    (reg_we_s),
        .reg_wa    (reg_wa_s),
        .reg_wd    (reg_wd_s),
        .wb_src    (wb_src_s),
`ifdef WB_ARB_FWD_EN
        .fwd_ra1   (fwd_ra1),
        .fwd_ra2   (fwd_ra2),
        .fwd_hit1  (fwd_hit1_s),
        .fwd_hit2  (fwd_hit2_s),
        .fwd_wd    (fwd_wd_s),
`endif
        .conf_cnt  (conf_cnt_s)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-source request state owned by the stimulus; the model releases a
    // source when it expects the transfer.
    logic [NREQ-1:0] pend;
    logic [4:0]      wa_a [NREQ];
    logic [31:0]     wd_a [NREQ];

    task automatic apply();
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_wa[5*i +: 5]   = wa_a[i];
            req_wd[32*i +: 32] = wd_a[i];
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Reference model: plain round-robin rules, popcount and saturation.
    // ------------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  src;
        logic [CW-1:0]  cnt;
        logic [CWS-1:0] cnt_s;
    } exp_t;

    exp_t        sb[$];
    int          m_ptr;
    int unsigned m_cnt, m_cnt_s;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [2:0]  m_src;

    task automatic model_init();
        m_ptr   = 0;
        m_cnt   = 0;
        m_cnt_s = 0;
        m_wa    = '0;
        m_wd    = '0;
        m_src   = '0;
    endtask

    always @(negedge clk) begin
        if (rst) begin : model_step
            int   win;
            int   nv;
            exp_t e;
            win = -1;
            nv  = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) nv += int'(req_valid[i]);
            if (arb_hold) win = -1;

            check("req_ready", req_ready, (win >= 0) ? (64'd1 << win) : 64'd0);
            check("req_ready_s", req_ready_s, (win >= 0) ? (64'd1 << win) : 64'd0);

            if (cnt_clr) begin
                m_cnt   = 0;
                m_cnt_s = 0;
            end else if (nv >= 2 && !arb_hold) begin
                if (m_cnt   < (1 << CW)  - 1) m_cnt++;
                if (m_cnt_s < (1 << CWS) - 1) m_cnt_s++;
            end

            if (win >= 0) begin
                m_wa      = wa_a[win];
                m_wd      = wd_a[win];
                m_src     = 3'(win);
                e.we      = (m_wa != 5'd0);
                m_ptr     = (win + 1) % NREQ;
                pend[win] = 1'b0;
            end else begin
                e.we = 1'b0;
            end
            e.wa    = m_wa;
            e.wd    = m_wd;
            e.src   = m_src;
            e.cnt   = CW'(m_cnt);
            e.cnt_s = CWS'(m_cnt_s);
            sb.push_back(e);
        end
    end

    // Monitor: compares registered outputs shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            sb.delete();
        end else if (sb.size() > 0) begin : mon_pop
            exp_t e;
            e = sb.pop_front();
            check("reg_we",     reg_we,     e.we);
            check("reg_wa",     reg_wa,     e.wa);
            check("reg_wd",     reg_wd,     e.wd);
            check("wb_src",     wb_src,     e.src);
            check("conf_cnt",   conf_cnt,   e.cnt);
            check("reg_we_s",   reg_we_s,   e.we);
            check("conf_cnt_s", conf_cnt_s, e.cnt_s);
        end else begin
            check("idle_we", reg_we, 1'b0);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic do_reset();
        next_cycle();
        rst      = 1'b0;
        pend     = '0;
        arb_hold = 1'b0;
        cnt_clr  = 1'b0;
        apply();
        model_init();
        next_cycle();
        next_cycle();
        rst = 1'b1;
    endtask

    // Keep presenting outstanding requests until the model has released them.
    task automatic drain();
        arb_hold = 1'b0;
        cnt_clr  = 1'b0;
        for (int c = 0; c < 10 && pend != '0; c++) begin
            next_cycle();
            apply();
        end
        check("drain_done", pend, '0);
    endtask

    // Watchdog: the bench never waits on DUT events, this only guards time.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rst      = 1'b0;
        arb_hold = 1'b0;
        cnt_clr  = 1'b0;
        pend     = '0;
        req_valid = '0;
        req_wa   = '0;
        req_wd   = '0;
`ifdef WB_ARB_FWD_EN
        fwd_ra1 = '0;
        fwd_ra2 = '0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            wa_a[i] = 5'(i + 1);
            wd_a[i] = 32'h1000_0000 + 32'(i);
        end
        model_init();
        apply();

        // Reset state with every source requesting.
        repeat (2) @(posedge clk);
        #1;
        pend = '1;
        apply();
        #1;
        check("rst_ready",  req_ready, '0);
        check("rst_we",     reg_we,    1'b0);
        check("rst_wa",     reg_wa,    '0);
        check("rst_wb_src", wb_src,    '0);
        check("rst_cnt",    conf_cnt,  '0);

        // Release: the pending requests are arbitrated from pointer 0.
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready", req_ready, 3'b001);
        drain();

        // Single source.
        do_reset();
        pend    = 3'b010;
        wa_a[1] = 5'd5;
        wd_a[1] = 32'hDEAD_BEEF;
        apply();
        @(negedge clk);
        check("single_ready", req_ready, 3'b010);
        next_cycle();
        apply();
        check("single_we",  reg_we, 1'b1);
        check("single_wa",  reg_wa, 5'd5);
        check("single_wd",  reg_wd, 32'hDEAD_BEEF);
        check("single_src", wb_src, 3'd1);

        // Round robin with all three sources continuously valid.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            pend = '1;
            for (int i = 0; i < NREQ; i++) begin
                wa_a[i] = 5'(8 + 3 * c + i);
                wd_a[i] = 32'hA000_0000 + 32'(16 * c + i);
            end
            apply();
            @(negedge clk);
            check("rr_order", req_ready, 3'b001 << (c % 3));
            next_cycle();
        end
        check("rr_cnt",   conf_cnt,   16'd6);
        check("rr_cnt_s", conf_cnt_s, 4'd6);
        drain();

        // Write to r0 is accepted but never reaches the regfile.
        do_reset();
        pend    = 3'b001;
        wa_a[0] = 5'd0;
        wd_a[0] = 32'h0000_1234;
        apply();
        @(negedge clk);
        check("r0_ready", req_ready, 3'b001);
        next_cycle();
        check("r0_we", reg_we, 1'b0);
        pend    = 3'b011;
        wa_a[0] = 5'd2;
        wa_a[1] = 5'd3;
        apply();
        @(negedge clk);
        check("r0_ptr", req_ready, 3'b010);
        drain();

        // Hold: four frozen cycles, then resume at the frozen pointer (1).
        do_reset();
        pend    = 3'b001;
        wa_a[0] = 5'd4;
        apply();
        next_cycle();
        pend     = '1;
        arb_hold = 1'b1;
        apply();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("hold_ready", req_ready, '0);
            next_cycle();
            check("hold_we", reg_we, 1'b0);
            if (c == 3) arb_hold = 1'b0;
            apply();
        end
        @(negedge clk);
        check("hold_resume", req_ready, 3'b010);
        drain();

        // Counter saturation (narrow instance) and clear-over-increment.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            pend = '1;
            apply();
            next_cycle();
        end
        check("cnt_sat_s", conf_cnt_s, 4'hF);
        check("cnt_20",    conf_cnt,   16'd20);
        pend    = '1;
        cnt_clr = 1'b1;
        apply();
        next_cycle();
        cnt_clr = 1'b0;
        check("cnt_clr",   conf_cnt,   '0);
        check("cnt_clr_s", conf_cnt_s, '0);
        drain();

        // Reset in the cycle after a transfer discards the pending write.
        do_reset();
        pend    = 3'b010;
        wa_a[1] = 5'd9;
        wd_a[1] = 32'hCAFE_F00D;
        apply();
        next_cycle();
        apply();
        check("midrst_pre", reg_we, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_we", reg_we, 1'b0);
        check("midrst_wa", reg_wa, 5'd0);
        model_init();
        next_cycle();
        next_cycle();
        rst = 1'b1;

`ifdef WB_ARB_FWD_EN
        // Forwarding of the in-flight write.
        do_reset();
        pend    = 3'b001;
        wa_a[0] = 5'd7;
        wd_a[0] = 32'hA5A5_A5A5;
        apply();
        next_cycle();
        apply();
        fwd_ra1 = 5'd7;
        fwd_ra2 = 5'd0;
        #1;
        check("fwd_hit1", fwd_hit1, 1'b1);
        check("fwd_hit2", fwd_hit2, 1'b0);
        check("fwd_wd",   fwd_wd,   32'hA5A5_A5A5);
        next_cycle();
        apply();
        check("fwd_idle", fwd_hit1, 1'b0);
`endif

        // Randomized traffic with random hold and clear.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 50) begin
                    pend[i] = 1'b1;
                    wa_a[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    wd_a[i] = $urandom;
                end
            end
            arb_hold = ($urandom_range(0, 99) < 15);
            cnt_clr  = ($urandom_range(0, 99) < 3);
            apply();
        end
        drain();
        repeat (3) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
